// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 definitions for the PC-select/sequencing logic.
//   - instruction codes used by fetch/sequencing decisions
//   - sequencer state encoding (the value also appears on the 'state' output)
//   - mispredict helper shared by the sequencer
package y86_pkg;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RET_WAIT  = 2'd1,
    HALT_PEND = 2'd2,
    HALTED    = 2'd3
  } seq_state_t;

  // A jXX reaching M with a false condition means the "taken" prediction was wrong.
  function automatic logic is_mispredict(input logic [3:0] m_icode, input logic m_cnd);
    return (m_icode == IJXX) && !m_cnd;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle of pipeline-side signals around the PC sequencer.
//   master modport: pipeline/hazard side (drives fetch/M/W info, sees controls)
//   slave  modport: pc_sequencer (sees fetch/M/W info, drives pc and controls)
//   Inputs to the sequencer : f_icode, f_valc, f_valp, m_icode, m_cnd, m_vala,
//                             w_icode, w_valm, hazard_stall
//   Outputs of the sequencer: pc, f_stall, d_bubble, e_bubble, halted, state
interface pc_sequencer_if #(
  parameter int ADDR_W = 64
);

  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valc;
  logic [ADDR_W-1:0] f_valp;
  logic [3:0]        m_icode;
  logic              m_cnd;
  logic [ADDR_W-1:0] m_vala;
  logic [3:0]        w_icode;
  logic [ADDR_W-1:0] w_valm;
  logic              hazard_stall;

  logic [ADDR_W-1:0] pc;
  logic              f_stall;
  logic              d_bubble;
  logic              e_bubble;
  logic              halted;
  logic [1:0]        state;

  modport master (
    output f_icode, f_valc, f_valp, m_icode, m_cnd, m_vala, w_icode, w_valm, hazard_stall,
    input  pc, f_stall, d_bubble, e_bubble, halted, state
  );

  modport slave (
    input  f_icode, f_valc, f_valp, m_icode, m_cnd, m_vala, w_icode, w_valm, hazard_stall,
    output pc, f_stall, d_bubble, e_bubble, halted, state
  );

endinterface

// File: rtl/pc_predict.sv
// pc_predict: next-PC prediction from the instruction currently being fetched.
//   f_icode_i  : icode of the fetched instruction
//   f_valc_i   : constant word (jump/call target)
//   f_valp_i   : fall-through address
//   pred_pc_o  : predicted next fetch address (jXX always predicted taken)
module pc_predict
  import y86_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [3:0]        f_icode_i,
  input  logic [ADDR_W-1:0] f_valc_i,
  input  logic [ADDR_W-1:0] f_valp_i,
  output logic [ADDR_W-1:0] pred_pc_o
);

  // Jumps and calls redirect to their constant; everything else falls through.
  always_comb begin
    pred_pc_o = f_valp_i;
    case (f_icode_i)
      IJXX, ICALL: pred_pc_o = f_valc_i;
      default:     pred_pc_o = f_valp_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: predicted-PC register, fetch-address select and the
// ret/halt sequencing state machine of the pipelined Y86-64 core.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pc_sequencer_if.slave
//             in : f_icode/f_valc/f_valp, m_icode/m_cnd/m_vala,
//                  w_icode/w_valm, hazard_stall
//             out: pc (combinational fetch address), f_stall, d_bubble,
//                  e_bubble, halted (sticky), state (0 RUN .. 3 HALTED)
module pc_sequencer
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter int                RET_DRAIN = 3
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);

  localparam int CNT_W = (RET_DRAIN < 1) ? 1 : $clog2(RET_DRAIN + 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;

  logic [ADDR_W-1:0] pred_next_s;
  logic [ADDR_W-1:0] pc_s;
  logic              mispredict_s;
  logic              ret_in_w_s;
  logic              f_stall_s;
  logic              d_bubble_s;
  logic              e_bubble_s;

  pc_predict #(.ADDR_W(ADDR_W)) u_predict (
    .f_icode_i (bus.f_icode),
    .f_valc_i  (bus.f_valc),
    .f_valp_i  (bus.f_valp),
    .pred_pc_o (pred_next_s)
  );

  // Fetch-address select: correction from M beats the ret target from W,
  // which beats the prediction.
  always_comb begin
    mispredict_s = is_mispredict(bus.m_icode, bus.m_cnd);
    ret_in_w_s   = (bus.w_icode == IRET);
    if (mispredict_s) begin
      pc_s = bus.m_vala;
    end else if (ret_in_w_s) begin
      pc_s = bus.w_valm;
    end else begin
      pc_s = pred_pc_q;
    end
  end

  // Next state, drain counter and stall/bubble controls.
  always_comb begin
    state_d    = state_q;
    ret_cnt_d  = ret_cnt_q;
    f_stall_s  = 1'b0;
    d_bubble_s = 1'b0;
    e_bubble_s = 1'b0;
    if (state_q == HALTED) begin
      // Terminal: nothing, not even a mispredict, restarts fetch.
      f_stall_s  = 1'b1;
      d_bubble_s = 1'b1;
    end else if (mispredict_s) begin
      // Squash the wrong-path instructions in D and E; any ret/halt seen on
      // that path is cancelled by returning to RUN.
      d_bubble_s = 1'b1;
      e_bubble_s = 1'b1;
      state_d    = RUN;
      ret_cnt_d  = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        RUN: begin
          if (bus.hazard_stall) begin
            // Load/use stall: hold F; E bubble comes from the hazard unit.
            f_stall_s = 1'b1;
          end else if (bus.f_icode == IRET) begin
            state_d   = RET_WAIT;
            ret_cnt_d = CNT_W'(RET_DRAIN);
          end else if (bus.f_icode == IHALT) begin
            state_d = HALT_PEND;
          end else begin
            state_d = RUN;
          end
        end
        RET_WAIT: begin
          if (ret_in_w_s) begin
            // Return address is known: fetch from it this cycle and let
            // pred_pc follow the instruction fetched there.
            state_d   = RUN;
            ret_cnt_d = {CNT_W{1'b0}};
          end else begin
            f_stall_s  = 1'b1;
            d_bubble_s = 1'b1;
            if (!bus.hazard_stall && (ret_cnt_q != {CNT_W{1'b0}})) begin
              ret_cnt_d = ret_cnt_q - CNT_W'(1);
            end else begin
              ret_cnt_d = ret_cnt_q;
            end
          end
        end
        HALT_PEND: begin
          f_stall_s  = 1'b1;
          d_bubble_s = 1'b1;
          if (bus.w_icode == IHALT) begin
            state_d = HALTED;
          end else begin
            state_d = HALT_PEND;
          end
        end
        default: begin
          f_stall_s  = 1'b1;
          d_bubble_s = 1'b1;
          state_d    = state_q;
        end
      endcase
    end

    if (f_stall_s) begin
      pred_pc_d = pred_pc_q;
    end else begin
      pred_pc_d = pred_next_s;
    end
  end

  // Sequencer registers: state, ret drain counter and predicted PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      ret_cnt_q <= {CNT_W{1'b0}};
      pred_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
      pred_pc_q <= pred_pc_d;
    end
  end

  assign bus.pc       = pc_s;
  assign bus.f_stall  = f_stall_s;
  assign bus.d_bubble = d_bubble_s;
  assign bus.e_bubble = e_bubble_s;
  assign bus.halted   = (state_q == HALTED);
  assign bus.state    = state_q;

endmodule
